onset_enumerator: RTL and testbench

ONSET_ENUMERATOR -- requirements
Module: onset_enumerator

---
 rtl/onset_enumerator_pkg.sv | 13 +
 rtl/onset_enumerator_sync_fifo.sv | 59 +++++
 rtl/onset_enumerator.sv | 119 +++++++++++
 tb/tb_onset_enumerator.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onset_enumerator_pkg.sv
// Shared types and defaults for the on-set enumerator.
package onset_enumerator_pkg;

  localparam int N_IN_DEFAULT = 17;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/onset_enumerator_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; any DEPTH >= 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; dout is forced to zero while empty so stale words never show.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/onset_enumerator.sv
// Sweeps every input vector through an external function and streams the on-set minterms.
module onset_enumerator
  import onset_enumerator_pkg::*;
#(
  parameter int N_IN       = N_IN_DEFAULT,
  parameter int FN_LAT     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] fn_x,
  input  logic            fn_y,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N_IN-1:0] m_data,
  output logic [N_IN:0]   onset_count,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t          state;
  state_t          state_nx;
  logic [N_IN-1:0] vec;
  logic            issue;
  logic            start_sweep;
  logic            ret_valid;
  logic [N_IN-1:0] ret_vec;
  logic            push;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  int              in_flight;

  assign fn_x        = vec;
  assign start_sweep = start && (state == IDLE || state == DONE);
  // Credit check: every vector in flight already owns a FIFO slot.
  assign issue       = (state == RUN) && !fifo_full &&
                       (int'(fifo_count) + in_flight < FIFO_DEPTH);
  assign push        = ret_valid && fn_y;

  if (FN_LAT == 0) begin : g_comb
    assign ret_valid = issue;
    assign ret_vec   = vec;
    assign in_flight = 0;
  end else begin : g_delay
    logic [FN_LAT-1:0] dl_valid;
    logic [N_IN-1:0]   dl_vec [FN_LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dl_valid <= '0;
        for (int i = 0; i < FN_LAT; i++) dl_vec[i] <= '0;
      end else begin
        dl_valid[0] <= issue;
        dl_vec[0]   <= vec;
        for (int i = 1; i < FN_LAT; i++) begin
          dl_valid[i] <= dl_valid[i-1];
          dl_vec[i]   <= dl_vec[i-1];
        end
      end
    end

    assign ret_valid = dl_valid[FN_LAT-1];
    assign ret_vec   = dl_vec[FN_LAT-1];
    assign in_flight = $countones(dl_valid);
  end

  sync_fifo #(
    .WIDTH (N_IN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ret_vec),
    .pop   (m_ready),
    .dout  (m_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vec         <= '0;
      onset_count <= '0;
    end else begin
      state <= state_nx;
      if (start_sweep) begin
        vec         <= '0;
        onset_count <= '0;
      end else begin
        // The counter parks on all-ones rather than wrapping.
        if (issue && !(&vec)) vec <= vec + 1'b1;
        if (push) onset_count <= onset_count + 1'b1;
      end
    end
  end

  // NOTE: default assigned first so no path through the case leaves state_nx unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (issue && (&vec)) state_nx = DRAIN;
      DRAIN:      if (in_flight == 0 && fifo_empty) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_onset_enumerator.sv
// Self-checking bench: three enumerator instances against a list-based on-set model.
module tb_onset_enumerator;

  localparam int NA = 12;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic          start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [NA-1:0] fn_x_a, fn_x_b;
  logic [NC-1:0] fn_x_c;
  logic          fn_y_a, fn_y_b, fn_y_c;
  logic          m_valid_a, m_valid_b, m_valid_c;
  logic          m_ready_a = 1'b1, m_ready_b = 1'b1, m_ready_c = 1'b1;
  logic [NA-1:0] m_data_a, m_data_b;
  logic [NC-1:0] m_data_c;
  logic [NA:0]   onset_count_a, onset_count_b;
  logic [NC:0]   onset_count_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;

  logic [NA-1:0] hist_b [3];
  logic [15:0]   tbl_c = '0;
  logic          rand_b = 1'b0;
  int            mode_c = 1;

  int exp_a[$];
  int exp_c[$];
  int rcv_a = 0, rcv_b = 0, rcv_c = 0;
  logic          hold_c = 1'b0;
  logic [NC-1:0] held_c = '0;

  // Function under test in its boolean form (bit positions scaled to a 12-bit sweep).
  function automatic logic fa(input logic [NA-1:0] v);
    return v[11] & v[10] & v[9] & v[7] & ~v[8] & ~v[6];
  endfunction

  assign fn_y_a = fa(fn_x_a);
  assign fn_y_b = fa(hist_b[2]);
  assign fn_y_c = tbl_c[fn_x_c];

  always @(posedge clk) begin
    hist_b[0] <= fn_x_b;
    hist_b[1] <= hist_b[0];
    hist_b[2] <= hist_b[1];
  end

  onset_enumerator #(.N_IN(NA), .FN_LAT(0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .fn_x(fn_x_a), .fn_y(fn_y_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .onset_count(onset_count_a), .busy(busy_a), .done(done_a));

  onset_enumerator #(.N_IN(NA), .FN_LAT(3), .FIFO_DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .fn_x(fn_x_b), .fn_y(fn_y_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .onset_count(onset_count_b), .busy(busy_b), .done(done_b));

  onset_enumerator #(.N_IN(NC), .FN_LAT(0), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .fn_x(fn_x_c), .fn_y(fn_y_c),
    .m_valid(m_valid_c), .m_ready(m_ready_c), .m_data(m_data_c),
    .onset_count(onset_count_c), .busy(busy_c), .done(done_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stream scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_c = 1'b0;
    end else begin
      if (m_valid_a && m_ready_a) begin
        if (rcv_a < exp_a.size()) check("a_data", m_data_a, exp_a[rcv_a]);
        else check("a_extra_beats", rcv_a + 1, exp_a.size());
        rcv_a++;
      end
      if (m_valid_b && m_ready_b) begin
        if (rcv_b < exp_a.size()) check("b_data", m_data_b, exp_a[rcv_b]);
        else check("b_extra_beats", rcv_b + 1, exp_a.size());
        rcv_b++;
      end
      if (hold_c) begin
        check("c_hold_valid", m_valid_c, 1);
        check("c_hold_data", m_data_c, held_c);
      end
      if (m_valid_c && m_ready_c) begin
        if (rcv_c < exp_c.size()) check("c_data", m_data_c, exp_c[rcv_c]);
        else check("c_extra_beats", rcv_c + 1, exp_c.size());
        rcv_c++;
      end
      hold_c = m_valid_c && !m_ready_c;
      held_c = m_data_c;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_ready_b = rand_b ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_ready_c = (mode_c == 2) ? 1'($urandom_range(0, 1)) : (mode_c == 1);
  endtask

  task automatic pulse(input logic [2:0] mask);
    start_a = mask[0];
    start_b = mask[1];
    start_c = mask[2];
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  function automatic logic sel_done(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int which, input int budget, input string tag, output int n);
    n = 0;
    while (!sel_done(which) && n < budget) begin
      tick();
      n++;
    end
    check(tag, sel_done(which), 1);
  endtask

  function automatic void build_c();
    exp_c.delete();
    for (int v = 0; v < 16; v++) if (tbl_c[v]) exp_c.push_back(v);
  endfunction

  initial begin
    int n;

    // Model: a minterm is on-set when bits 11..6 read 111010.
    for (int v = 0; v < (1 << NA); v++) if (((v >> 6) & 63) == 58) exp_a.push_back(v);

    repeat (3) tick();
    check("rst_a_fn_x", fn_x_a, 0);
    check("rst_a_m_valid", m_valid_a, 0);
    check("rst_a_m_data", m_data_a, 0);
    check("rst_a_count", onset_count_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_b_m_valid", m_valid_b, 0);
    check("rst_c_done", done_c, 0);
    rst = 1'b0;
    tick();

    // Full sweep: combinational function (a) and 3-cycle function with random backpressure (b).
    rcv_a = 0;
    rcv_b = 0;
    rand_b = 1'b1;
    pulse(3'b011);
    check("a_busy_run", busy_a, 1);
    check("a_done_dropped", done_a, 0);
    wait_done(0, 20000, "a_done_timeout", n);
    wait_done(1, 40000, "b_done_timeout", n);
    check("a_count", onset_count_a, 64);
    check("a_beats", rcv_a, 64);
    check("b_count", onset_count_b, 64);
    check("b_beats", rcv_b, 64);
    check("a_busy_done", busy_a, 0);
    check("a_fn_x_hold", fn_x_a, 4095);
    repeat (5) tick();
    check("a_count_hold", onset_count_a, 64);
    check("a_done_hold", done_a, 1);

    // Backpressure: every vector is on-set and the sink stalls.
    tbl_c = 16'hFFFF;
    build_c();
    rcv_c = 0;
    mode_c = 0;
    pulse(3'b100);
    repeat (10) tick();
    check("c_stall_valid", m_valid_c, 1);
    check("c_stall_head", m_data_c, 0);
    check("c_stall_fn_x", fn_x_c, 4);
    check("c_stall_count", onset_count_c, 4);
    pulse(3'b100);
    repeat (3) tick();
    check("c_start_ignored_fn_x", fn_x_c, 4);
    check("c_start_ignored_busy", busy_c, 1);
    mode_c = 2;
    wait_done(2, 2000, "c_full_timeout", n);
    check("c_full_count", onset_count_c, 16);
    check("c_full_beats", rcv_c, 16);

    // Empty on-set: no beats, done within the latency bound.
    tbl_c = '0;
    build_c();
    rcv_c = 0;
    mode_c = 1;
    pulse(3'b100);
    wait_done(2, 100, "c_zero_timeout", n);
    check("c_zero_latency_ok", (n <= 17), 1);
    check("c_zero_count", onset_count_c, 0);
    check("c_zero_beats", rcv_c, 0);

    // Random truth table with random sink readiness.
    for (int r = 0; r < 3; r++) begin
      tbl_c = 16'($urandom);
      build_c();
      rcv_c = 0;
      mode_c = 2;
      pulse(3'b100);
      wait_done(2, 2000, "c_rand_timeout", n);
      check("c_rand_count", onset_count_c, exp_c.size());
      check("c_rand_beats", rcv_c, exp_c.size());
    end
    mode_c = 1;

    // Reset in the middle of a sweep.
    rcv_a = 0;
    pulse(3'b001);
    n = 0;
    while (fn_x_a != 12'd100 && n < 1000) begin
      tick();
      n++;
    end
    check("a_reached_100", fn_x_a, 100);
    rst = 1'b1;
    #1;
    check("mid_rst_fn_x", fn_x_a, 0);
    check("mid_rst_m_valid", m_valid_a, 0);
    check("mid_rst_m_data", m_data_a, 0);
    check("mid_rst_count", onset_count_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    tick();
    tick();
    rst = 1'b0;
    rcv_a = 0;
    repeat (5) tick();
    check("post_rst_m_valid", m_valid_a, 0);
    check("post_rst_busy", busy_a, 0);
    check("post_rst_fn_x", fn_x_a, 0);

    // Fresh sweep after reset, with a stray start during RUN.
    pulse(3'b001);
    repeat (50) tick();
    pulse(3'b001);
    check("a_stray_start_busy", busy_a, 1);
    wait_done(0, 20000, "a_resweep_timeout", n);
    check("a_resweep_count", onset_count_a, 64);
    check("a_resweep_beats", rcv_a, 64);

    // Repeat sweep started from DONE.
    rcv_a = 0;
    pulse(3'b001);
    check("a_repeat_busy", busy_a, 1);
    wait_done(0, 20000, "a_repeat_timeout", n);
    check("a_repeat_count", onset_count_a, 64);
    check("a_repeat_beats", rcv_a, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
